// File: rtl/ooo_commit_trace_buffer.sv
// Commit-trace capture buffer for the OoO core debug path.
// Ports: commit snoop (cmt_*), control (arm/mode/trig_pc/stop/flush),
//   drain (rd_valid/rd_ready/rd_data), status (count/state/overflow),
//   free-running counters (commit_cnt/flush_cnt).
module ooo_commit_trace_buffer #(
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 16,
   parameter int XLEN     = 32,
   parameter int POST_CNT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CHANNELS-1:0]      cmt_valid,
   input  logic [CHANNELS*XLEN-1:0] cmt_pc,
   input  logic [CHANNELS*32-1:0]   cmt_instr,
   input  logic [CHANNELS*5-1:0]    cmt_rd,
   input  logic [CHANNELS*XLEN-1:0] cmt_rd_data,
   input  logic                     flush,
   input  logic                     arm,
   input  logic [1:0]               mode,
   input  logic [XLEN-1:0]          trig_pc,
   input  logic                     stop,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [2*XLEN+36:0]       rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic [1:0]               state,
   output logic                     overflow,
   output logic [31:0]              commit_cnt,
   output logic [15:0]              flush_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 2*XLEN + 37;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_POST    = 2'd2,
      S_FROZEN  = 2'd3
   } state_t;

   state_t        st_q, st_d;
   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
   logic [CW-1:0] count_d, post_left, post_left_d;
   logic          overflow_d;
   logic          full_stop, full_stop_d;
   logic [1:0]    mode_q;
   logic [XLEN-1:0] trig_q;

   int   slot_ofs [CHANNELS];
   int   n_val, n_keep, trig_pos;
   int   room, used, total;
   logic trig_hit;
   logic pop;

   assign state    = st_q;
   assign rd_valid = (st_q == S_FROZEN) && (count != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

   // Compaction: each valid channel gets the next free slot offset,
   // so sparse valids never leave holes in the buffer.
   always_comb begin
      n_val    = 0;
      trig_hit = 1'b0;
      trig_pos = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         slot_ofs[i] = n_val;
         if (cmt_valid[i]) begin
            if (!trig_hit &&
                cmt_pc[i*XLEN +: XLEN] == trig_q) begin
               trig_hit = 1'b1;
               trig_pos = n_val;
            end
            n_val = n_val + 1;
         end
      end
   end

   always_comb begin
      st_d        = st_q;
      post_left_d = post_left;
      overflow_d  = overflow;
      full_stop_d = full_stop;
      n_keep      = 0;
      used        = 0;
      pop         = 1'b0;
      room        = DEPTH - int'(count);
      unique case (st_q)
         S_IDLE: ;
         S_CAPTURE: begin
            if (stop) begin
               st_d = S_FROZEN;
            end else if (mode_q == 2'd1) begin
               n_keep = (n_val > room) ? room : n_val;
               if (n_val > room) overflow_d = 1'b1;
               if (n_keep == room) begin
                  st_d        = S_FROZEN;
                  full_stop_d = 1'b1;
               end
            end else if (mode_q == 2'd2 && trig_hit) begin
               // Trigger entry plus younger same-cycle entries
               // consume the post-trigger budget.
               n_keep = (n_val > trig_pos + POST_CNT) ?
                        trig_pos + POST_CNT : n_val;
               used   = n_keep - trig_pos;
               post_left_d = CW'(POST_CNT - used);
               st_d = (used >= POST_CNT) ? S_FROZEN : S_POST;
            end else begin
               n_keep = n_val;
            end
         end
         S_POST: begin
            if (stop) begin
               st_d = S_FROZEN;
            end else begin
               n_keep = (n_val > int'(post_left)) ?
                        int'(post_left) : n_val;
               post_left_d = post_left - CW'(n_keep);
               if (post_left_d == '0) st_d = S_FROZEN;
            end
         end
         S_FROZEN: begin
            pop = rd_valid && rd_ready;
            // Stop-on-full keeps reporting commits it could not hold.
            if (full_stop && n_val != 0) overflow_d = 1'b1;
         end
         default: ;
      endcase
      // Overwrite-oldest: a full buffer drags rd_ptr along.
      total    = int'(count) + n_keep;
      rd_ptr_d = rd_ptr;
      if (total > DEPTH) begin
         count_d    = CW'(DEPTH);
         rd_ptr_d   = rd_ptr + PW'(total - DEPTH);
         overflow_d = 1'b1;
      end else begin
         count_d = CW'(total);
      end
      wr_ptr_d = wr_ptr + PW'(n_keep);
      if (pop) begin
         rd_ptr_d = rd_ptr + PW'(1);
         count_d  = count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q       <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         post_left  <= '0;
         overflow   <= 1'b0;
         full_stop  <= 1'b0;
         mode_q     <= 2'd0;
         trig_q     <= '0;
         commit_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         commit_cnt <= commit_cnt + 32'(n_val);
         if (flush) flush_cnt <= flush_cnt + 16'd1;
         if (arm) begin
            st_q      <= S_CAPTURE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_left <= '0;
            overflow  <= 1'b0;
            full_stop <= 1'b0;
            mode_q    <= mode;
            trig_q    <= trig_pc;
         end else begin
            st_q      <= st_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            count     <= count_d;
            post_left <= post_left_d;
            overflow  <= overflow_d;
            full_stop <= full_stop_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!arm) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (cmt_valid[i] && slot_ofs[i] < n_keep) begin
               mem[wr_ptr + PW'(slot_ofs[i])] <= {
                  cmt_pc[i*XLEN +: XLEN],
                  cmt_instr[i*32 +: 32],
                  cmt_rd[i*5 +: 5],
                  cmt_rd_data[i*XLEN +: XLEN]};
            end
         end
      end
   end

endmodule

// File: tb/tb_ooo_commit_trace_buffer.sv
// Scoreboard bench for ooo_commit_trace_buffer (2 ch, depth 16).
// Stimulus pushes expected drain entries; a monitor pops on each accept.
module tb_ooo_commit_trace_buffer;

   logic         clk;
   logic         rst;
   logic [1:0]   cmt_valid;
   logic [63:0]  cmt_pc;
   logic [63:0]  cmt_instr;
   logic [9:0]   cmt_rd;
   logic [63:0]  cmt_rd_data;
   logic         flush;
   logic         arm;
   logic [1:0]   mode;
   logic [31:0]  trig_pc;
   logic         stop;
   logic         rd_valid;
   logic         rd_ready;
   logic [100:0] rd_data;
   logic [4:0]   count;
   logic [1:0]   state;
   logic         overflow;
   logic [31:0]  commit_cnt;
   logic [15:0]  flush_cnt;

   int total = 0;
   int bad   = 0;
   int exp_commits = 0;
   logic [100:0] exp_q [$];

   ooo_commit_trace_buffer #(
      .CHANNELS(2), .DEPTH(16), .XLEN(32), .POST_CNT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
      .cmt_instr(cmt_instr), .cmt_rd(cmt_rd),
      .cmt_rd_data(cmt_rd_data), .flush(flush),
      .arm(arm), .mode(mode), .trig_pc(trig_pc),
      .stop(stop), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_data(rd_data),
      .count(count), .state(state),
      .overflow(overflow), .commit_cnt(commit_cnt),
      .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[15:0], 16'h0013};
   endfunction

   function automatic logic [100:0] ent(input logic [31:0] pc);
      return {pc, instr_of(pc), pc[6:2], ~pc};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst && rd_valid && rd_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL drain_extra: got %0h want none", rd_data);
         end else begin
            logic [100:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               bad++;
               $display("FAIL drain: got %0h want %0h", rd_data, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [1:0] v, input logic [31:0] p0,
                         input logic [31:0] p1);
      cmt_valid   = v;
      cmt_pc      = {p1, p0};
      cmt_instr   = {instr_of(p1), instr_of(p0)};
      cmt_rd      = {p1[6:2], p0[6:2]};
      cmt_rd_data = {~p1, ~p0};
      exp_commits += int'(v[0]) + int'(v[1]);
      step();
      cmt_valid = 2'b00;
   endtask

   task automatic do_arm(input logic [1:0] m, input logic [31:0] t);
      arm = 1'b1; mode = m; trig_pc = t;
      step();
      arm = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      rd_ready = 1'b1;
      while (rd_valid && g < 40) begin
         step();
         g++;
      end
      rd_ready = 1'b0;
      chk("drain_left", exp_q.size(), 0);
      chk("drain_rd_valid", rd_valid, 0);
      chk("drain_state", state, 3);
   endtask

   initial begin
      rst = 1'b0; cmt_valid = '0; cmt_pc = '0; cmt_instr = '0;
      cmt_rd = '0; cmt_rd_data = '0; flush = 1'b0; arm = 1'b0;
      mode = 2'd0; trig_pc = '0; stop = 1'b0; rd_ready = 1'b0;
      #3;
      chk("rst_state", state, 0);
      chk("rst_count", count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ccnt", commit_cnt, 0);
      chk("rst_fcnt", flush_cnt, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_rdd", rd_data, 0);
      #4 rst = 1'b1;

      // stop-on-full
      do_arm(2'd1, 32'h0);
      chk("m1_arm_state", state, 1);
      for (int c = 0; c < 10; c++) begin
         logic [31:0] pa;
         pa = 32'h1000 + 32'(8*c);
         commit(2'b11, pa, pa + 32'd4);
         if (c < 8) begin
            exp_q.push_back(ent(pa));
            exp_q.push_back(ent(pa + 32'd4));
         end
         if (c == 7) begin
            chk("m1_full_state", state, 3);
            chk("m1_full_count", count, 16);
            chk("m1_full_ovf", overflow, 0);
         end
      end
      chk("m1_count", count, 16);
      chk("m1_ovf", overflow, 1);
      chk("m1_ccnt", commit_cnt, exp_commits);
      drain();

      // wrap mode
      do_arm(2'd0, 32'h0);
      chk("m0_arm_count", count, 0);
      for (int k = 0; k < 20; k++) begin
         commit(2'b01, 32'h100 + 32'(4*k), 32'h0);
         if (k >= 4) exp_q.push_back(ent(32'h100 + 32'(4*k)));
      end
      do_stop();
      chk("m0_count", count, 16);
      chk("m0_ovf", overflow, 1);
      chk("m0_state", state, 3);
      chk("m0_ccnt", commit_cnt, exp_commits);
      chk("m0_first", rd_data[100:69], 32'h110);
      drain();

      // sparse valid and ready toggling
      do_arm(2'd0, 32'h0);
      commit(2'b10, 32'h999, 32'h300);
      exp_q.push_back(ent(32'h300));
      chk("sp_count1", count, 1);
      commit(2'b11, 32'h304, 32'h308);
      exp_q.push_back(ent(32'h304));
      exp_q.push_back(ent(32'h308));
      commit(2'b01, 32'h30C, 32'h998);
      exp_q.push_back(ent(32'h30C));
      do_stop();
      chk("sp_count4", count, 4);
      chk("sp_ovf", overflow, 0);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("tg_count3", count, 3);
      chk("tg_hold0", rd_data, exp_q[0]);
      step();
      chk("tg_hold1", rd_data, exp_q[0]);
      chk("tg_hold_cnt", count, 3);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("tg_count2", count, 2);
      chk("tg_next", rd_data, exp_q[0]);
      drain();
      step();
      chk("tg_stay_frozen", state, 3);

      // triggered capture, trigger on channel 1
      do_arm(2'd2, 32'h200);
      commit(2'b11, 32'h1F0, 32'h1F4);
      exp_q.push_back(ent(32'h1F0));
      exp_q.push_back(ent(32'h1F4));
      chk("m2_pre_state", state, 1);
      commit(2'b11, 32'h1FC, 32'h200);
      exp_q.push_back(ent(32'h1FC));
      exp_q.push_back(ent(32'h200));
      chk("m2_trig_state", state, 2);
      chk("m2_trig_count", count, 4);
      commit(2'b11, 32'h204, 32'h208);
      exp_q.push_back(ent(32'h204));
      exp_q.push_back(ent(32'h208));
      chk("m2_post_state", state, 2);
      commit(2'b11, 32'h20C, 32'h210);
      exp_q.push_back(ent(32'h20C));
      chk("m2_done_state", state, 3);
      chk("m2_done_count", count, 7);
      chk("m2_done_ovf", overflow, 0);
      drain();

      // trigger on channel 0, then async reset mid-POST
      do_arm(2'd2, 32'h400);
      commit(2'b11, 32'h400, 32'h404);
      chk("m2b_state", state, 2);
      chk("m2b_count", count, 2);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("ar_state", state, 0);
      chk("ar_count", count, 0);
      chk("ar_ovf", overflow, 0);
      chk("ar_ccnt", commit_cnt, 0);
      chk("ar_rdv", rd_valid, 0);
      exp_q.delete();
      exp_commits = 0;
      #2 rst = 1'b1;

      for (int f = 0; f < 3; f++) begin
         flush = 1'b1;
         step();
         flush = 1'b0;
         step();
      end
      chk("flush_cnt", flush_cnt, 3);
      chk("idle_state", state, 0);

      // arm during drain wins over the pop
      do_arm(2'd0, 32'h0);
      commit(2'b01, 32'h500, 32'h0);
      commit(2'b01, 32'h504, 32'h0);
      commit(2'b01, 32'h508, 32'h0);
      exp_q.push_back(ent(32'h500));
      exp_q.push_back(ent(32'h504));
      exp_q.push_back(ent(32'h508));
      do_stop();
      chk("ad_count", count, 3);
      rd_ready = 1'b1;
      step();
      chk("ad_pop_count", count, 2);
      arm = 1'b1; mode = 2'd0;
      cmt_valid = 2'b11;
      cmt_pc = {32'h604, 32'h600};
      exp_commits += 2;
      step();
      arm = 1'b0; rd_ready = 1'b0; cmt_valid = 2'b00;
      exp_q.delete();
      chk("ad_state", state, 1);
      chk("ad_count0", count, 0);
      chk("ad_rdv", rd_valid, 0);
      commit(2'b10, 32'h0, 32'h700);
      exp_q.push_back(ent(32'h700));
      chk("ad_count1", count, 1);
      do_stop();
      chk("ad_slot0", rd_data, ent(32'h700));
      drain();
      chk("ad_ccnt", commit_cnt, exp_commits);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
